fifox_multi_mvb_reader: RTL and testbench

- Downstream stage of the multi-port FIFOX: drains up to ITEMS read ports per cycle into a registered MVB output word with full SRC_RDY/DST_RDY backpressure.
- Converts the FIFO's per-port EMPTY/RD interface into MVB items. Items are packed contiguously from slot 0, and FIFO order is preserved.
- Sits between the FIFOX_MULTI read side and any MVB consumer.

---
 rtl/fifox_multi_mvb_reader.sv | 124 ++++++++++++
 tb/tb_fifox_multi_mvb_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifox_multi_mvb_reader.sv
// Multi-port FIFOX read side to registered MVB word, with SRC_RDY/DST_RDY backpressure.
// Optional fill-wait control: define FIFOX_MULTI_MVB_READER_FILL_WAIT_EN.
module fifox_multi_mvb_reader #(
  parameter int unsigned ITEMS        = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FILL_TIMEOUT = 16
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [ITEMS*DATA_WIDTH-1:0]  FIFO_DO,
  input  logic [ITEMS-1:0]             FIFO_EMPTY,
  output logic [ITEMS-1:0]             FIFO_RD,
  output logic [ITEMS*DATA_WIDTH-1:0]  TX_DATA,
  output logic [ITEMS-1:0]             TX_VLD,
  output logic                         TX_SRC_RDY,
  input  logic                         TX_DST_RDY
);

  localparam int unsigned CW = $clog2(ITEMS + 1);

  function automatic logic [ITEMS-1:0] therm(input logic [CW-1:0] k);
    logic [ITEMS-1:0] t;
    for (int unsigned i = 0; i < ITEMS; i++) t[i] = (CW'(i) < k);
    return t;
  endfunction

  logic [CW-1:0] avail;
  logic [CW-1:0] reads;
  logic [CW-1:0] off;

  // Leading run of non-empty ports; a gap stops the count so FIFO order is kept.
  always_comb begin
    logic stop;
    avail = '0;
    stop  = 1'b0;
    for (int unsigned i = 0; i < ITEMS; i++) begin
      if (!stop && !FIFO_EMPTY[i]) avail = avail + CW'(1);
      else                         stop  = 1'b1;
    end
  end

  always_comb FIFO_RD = RESET_N ? therm(reads) : '0;

`ifdef FIFOX_MULTI_MVB_READER_FILL_WAIT_EN
  localparam int unsigned TW = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_SENDING} state_t;

  state_t        state, state_d;
  logic [CW-1:0] n, n_d;
  logic [TW-1:0] cnt;

  always_comb begin
    state_d = state;
    n_d     = n;
    off     = '0;
    reads   = '0;
    case (state)
      ST_FILLING: begin
        off     = n;
        reads   = (avail < CW'(ITEMS) - n) ? avail : CW'(ITEMS) - n;
        n_d     = n + reads;
        if (n_d == CW'(ITEMS) || cnt == TW'(FILL_TIMEOUT - 1)) state_d = ST_SENDING;
      end
      default: begin
        // EMPTY always reloads; SENDING reloads only when the word is taken.
        if (state == ST_EMPTY || TX_DST_RDY) begin
          reads   = avail;
          n_d     = avail;
          state_d = (avail == CW'(ITEMS)) ? ST_SENDING :
                    (avail != '0)         ? ST_FILLING : ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= ST_EMPTY;
      n          <= '0;
      cnt        <= '0;
      TX_VLD     <= '0;
      TX_SRC_RDY <= 1'b0;
    end else begin
      state      <= state_d;
      n          <= n_d;
      cnt        <= (state == ST_FILLING) ? cnt + TW'(1) : '0;
      TX_VLD     <= therm(n_d);
      TX_SRC_RDY <= (state_d == ST_SENDING);
    end
  end
`else
  logic load_en;

  always_comb begin
    load_en = !TX_SRC_RDY || TX_DST_RDY;
    off     = '0;
    reads   = load_en ? avail : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      TX_VLD     <= '0;
      TX_SRC_RDY <= 1'b0;
    end else if (load_en) begin
      TX_VLD     <= therm(avail);
      TX_SRC_RDY <= (avail != '0);
    end
  end
`endif

  // Read items land at slots off..off+reads-1; all other slots hold.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      TX_DATA <= '0;
    end else begin
      for (int unsigned j = 0; j < ITEMS; j++) begin
        if (CW'(j) >= off && CW'(j) < off + reads)
          TX_DATA[j*DATA_WIDTH +: DATA_WIDTH] <= FIFO_DO[(j - 32'(off))*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifox_multi_mvb_reader.sv
// Scoreboard bench for fifox_multi_mvb_reader: driver pushes expected words, negedge monitor checks them.
module tb_fifox_multi_mvb_reader;

  localparam int unsigned ITEMS = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned WW    = ITEMS * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WW-1:0]     fifo_do = '0;
  logic [ITEMS-1:0]  fifo_empty = '1;
  logic [ITEMS-1:0]  fifo_rd;
  logic [WW-1:0]     tx_data;
  logic [ITEMS-1:0]  tx_vld;
  logic              tx_src_rdy;
  logic              tx_dst_rdy = 1'b1;

  typedef struct {
    logic [ITEMS-1:0] vld;
    logic [WW-1:0]    data;
  } word_t;

  word_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned tag = 0;
  bit          auto_push = 1'b1;

  fifox_multi_mvb_reader #(
    .ITEMS(ITEMS),
    .DATA_WIDTH(DW),
    .FILL_TIMEOUT(4)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .FIFO_DO(fifo_do),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_RD(fifo_rd),
    .TX_DATA(tx_data),
    .TX_VLD(tx_vld),
    .TX_SRC_RDY(tx_src_rdy),
    .TX_DST_RDY(tx_dst_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] slot_mask(input logic [ITEMS-1:0] v);
    logic [WW-1:0] m;
    for (int i = 0; i < ITEMS; i++) m[i*DW +: DW] = v[i] ? '1 : '0;
    return m;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, check FIFO_RD, queue the word it should load.
  task automatic step(input logic rst, input logic [ITEMS-1:0] empty, input logic dst,
                      input logic [ITEMS-1:0] exp_rd);
    word_t w;
    @(posedge clk);
    #1;
    rst_n      = rst;
    fifo_empty = empty;
    tx_dst_rdy = dst;
    tag++;
    for (int i = 0; i < ITEMS; i++) fifo_do[i*DW +: DW] = {16'hA5A5, tag[23:0], 24'(i)};
    #1;
    chk("fifo_rd", WW'(fifo_rd), WW'(exp_rd));
    if (auto_push && exp_rd != '0) begin
      w.vld  = exp_rd;
      w.data = fifo_do;
      sb.push_back(w);
    end
  endtask

  always @(negedge clk) begin : monitor
    word_t e;
    logic [WW-1:0] m;
    if (tx_src_rdy === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got vld=%b, want no valid word", tx_vld);
      end else begin
        e = sb[0];
        m = slot_mask(e.vld);
        if (tx_vld !== e.vld || (tx_data & m) !== (e.data & m)) begin
          n_err++;
          $display("FAIL tx_word: got vld=%b data=%h, want vld=%b data=%h",
                   tx_vld, tx_data & m, e.vld, e.data & m);
        end
        if (tx_dst_rdy) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;

    // Reset with a full FIFO: strobes must stay low, outputs cleared.
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    chk("rst_src_rdy", WW'(tx_src_rdy), '0);
    chk("rst_vld", WW'(tx_vld), '0);
    chk("rst_data", tx_data, '0);

    // Full FIFO streaming
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 1'b1, 4'b1111);
    chk("stream_src_rdy", WW'(tx_src_rdy), WW'(1));

    // Stall: word held, no reads; then transfer and reload together
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b0, 4'b0000);
    step(1'b1, 4'b0000, 1'b1, 4'b1111);

    // Reset while a word is pending under stall: discarded
    step(1'b0, 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 4'b1111, 1'b1, 4'b0000);
    sb.delete();
    chk("rst2_src_rdy", WW'(tx_src_rdy), '0);
    chk("rst2_vld", WW'(tx_vld), '0);
    step(1'b1, 4'b0000, 1'b1, 4'b1111);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk("drain_src_rdy", WW'(tx_src_rdy), '0);

`ifndef FIFOX_MULTI_MVB_READER_FILL_WAIT_EN
    // Partial word of two, then bubble
    step(1'b1, 4'b1100, 1'b1, 4'b0011);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk("partial_then_idle", WW'(tx_src_rdy), '0);

    // A gap after port 0 limits the read to one item
    step(1'b1, 4'b0110, 1'b1, 4'b0001);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
`else
    auto_push = 1'b0;
    // Single item, flushed by timeout in cycle 5
    step(1'b1, 4'b1110, 1'b1, 4'b0001);
    w.vld  = 4'b0001;
    w.data = '0;
    w.data[0 +: DW] = fifo_do[0 +: DW];
    sb.push_back(w);
    for (int c = 1; c <= 4; c++) begin
      step(1'b1, 4'b1111, 1'b1, 4'b0000);
      chk("fill_wait_src_rdy", WW'(tx_src_rdy), '0);
    end
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk("fill_timeout_src_rdy", WW'(tx_src_rdy), WW'(1));

    // 1 + 2 + 1 items accumulate into one full word in cycle 3
    w.vld  = 4'b1111;
    w.data = '0;
    step(1'b1, 4'b1110, 1'b1, 4'b0001);
    w.data[0 +: DW] = fifo_do[0 +: DW];
    step(1'b1, 4'b1100, 1'b1, 4'b0011);
    w.data[DW +: 2*DW] = fifo_do[0 +: 2*DW];
    step(1'b1, 4'b1110, 1'b1, 4'b0001);
    w.data[3*DW +: DW] = fifo_do[0 +: DW];
    sb.push_back(w);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk("fill_full_src_rdy", WW'(tx_src_rdy), WW'(1));
`endif

    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    step(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk("sb_drained", WW'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
